// File: rtl/cr_prefix_fe_pack_pkg.sv
// Shared types and helpers for the prefix feature-counter packer.
package cr_prefix_fe_pack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TRL  = 2'd2
    } pk_state_e;

    localparam int unsigned N_CTR_DEFAULT = 64;

    function automatic int unsigned pk_beats(input int unsigned n_ctr);
        return 4 * n_ctr / 8;
    endfunction

    localparam int unsigned PK_BEATS = pk_beats(N_CTR_DEFAULT);

    typedef struct packed {
        logic [31:0] reserved;
        logic [15:0] nz_cnt;
        logic [15:0] byte_sum;
    } pk_trailer_t;

endpackage

// File: rtl/cr_prefix_fe_pack_if.sv
// 64-bit AXI-stream beat channel from the packer to the TLV builder.
interface cr_prefix_fe_pack_if;
    logic [63:0] pk_tdata;
    logic        pk_tvalid;
    logic        pk_tready;
    logic        pk_tlast;
    logic        pk_tuser;

    modport master (output pk_tdata, pk_tvalid, pk_tlast, pk_tuser, input pk_tready);
    modport slave  (input pk_tdata, pk_tvalid, pk_tlast, pk_tuser, output pk_tready);
endinterface

// File: rtl/cr_prefix_fe_pack_sum8.sv
// Combinational byte sum and nonzero-byte count of one 64-bit beat.
module cr_prefix_pk_sum8 (
    input  logic [63:0] beat,
    output logic [10:0] byte_sum,
    output logic [3:0]  nz_cnt
);
    always_comb begin
        byte_sum = '0;
        nz_cnt   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            byte_sum = byte_sum + 11'(beat[k*8 +: 8]);
            nz_cnt   = nz_cnt + 4'(|beat[k*8 +: 8]);
        end
    end
endmodule

// File: rtl/cr_prefix_fe_pack.sv
// Snapshots the four feature-counter blocks and streams them as 64-bit beats,
// optionally followed by a trailer carrying byte sum and nonzero count.
module cr_prefix_fe_pack
    import cr_prefix_fe_pack_pkg::*;
#(
    parameter int unsigned N_CTR      = 64,
    parameter bit          TRAILER_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CTR*8-1:0]   fe_ctr_1,
    input  logic [N_CTR*8-1:0]   fe_ctr_2,
    input  logic [N_CTR*8-1:0]   fe_ctr_3,
    input  logic [N_CTR*8-1:0]   fe_ctr_4,
    input  logic                 fe_snap,
    cr_prefix_fe_pack_if.master  pk,
    output logic                 pk_busy,
    output logic                 pk_snap_drop
);
    localparam int unsigned BEATS = pk_beats(N_CTR);
    localparam int unsigned BW    = $clog2(BEATS);
    localparam int unsigned SNAP_W = 4 * N_CTR * 8;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DATA = DATA;
    localparam logic [1:0] S_TRL  = TRL;

    logic [1:0]        state;
    logic [BW-1:0]     beat;
    logic [SNAP_W-1:0] snap;
    logic [15:0]       byte_sum;
    logic [15:0]       nz_cnt;

    logic [63:0]       beat_data;
    logic [10:0]       s8_sum;
    logic [3:0]        s8_nz;
    logic              hs;
    logic              last_data;
    logic              final_hs;
    logic              capture;
    pk_trailer_t       trailer;

    // Blocks concatenated high-to-low make beat w land at bit offset w*64.
    assign beat_data = snap[int'(beat) * 64 +: 64];

    cr_prefix_pk_sum8 u_sum8 (
        .beat     (beat_data),
        .byte_sum (s8_sum),
        .nz_cnt   (s8_nz)
    );

    assign hs        = pk.pk_tvalid & pk.pk_tready;
    assign last_data = (beat == BW'(BEATS - 1));
    assign final_hs  = hs & ((state == S_TRL) |
                             ((state == S_DATA) & last_data & !TRAILER_EN));
    // A snapshot on the final handshake restarts without an idle bubble.
    assign capture   = fe_snap & ((state == S_IDLE) | final_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            beat     <= '0;
            snap     <= '0;
            byte_sum <= '0;
            nz_cnt   <= '0;
        end else if (capture) begin
            state    <= S_DATA;
            beat     <= '0;
            snap     <= {fe_ctr_4, fe_ctr_3, fe_ctr_2, fe_ctr_1};
            byte_sum <= '0;
            nz_cnt   <= '0;
        end else if (hs) begin
            case (state)
                S_DATA: begin
                    byte_sum <= byte_sum + 16'(s8_sum);
                    nz_cnt   <= nz_cnt + 16'(s8_nz);
                    if (last_data) begin
                        beat  <= '0;
                        state <= TRAILER_EN ? S_TRL : S_IDLE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                S_TRL:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        trailer          = '0;
        trailer.nz_cnt   = nz_cnt;
        trailer.byte_sum = byte_sum;
    end

    always_comb begin
        pk.pk_tvalid = (state != S_IDLE);
        pk.pk_tuser  = (state == S_TRL);
        pk.pk_tlast  = (state == S_TRL) | ((state == S_DATA) & last_data & !TRAILER_EN);
        case (state)
            S_DATA:  pk.pk_tdata = beat_data;
            S_TRL:   pk.pk_tdata = trailer;
            default: pk.pk_tdata = '0;
        endcase
    end

    assign pk_busy      = (state != S_IDLE);
    assign pk_snap_drop = fe_snap & pk_busy & ~final_hs;

endmodule

// File: tb/tb_cr_prefix_fe_pack.sv
// Self-checking bench for cr_prefix_fe_pack: table vectors, corner sequences
// and randomized traffic against a stream-level queue model.
module tb_cr_prefix_fe_pack;
    localparam int unsigned N = 64;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        int          fill;
        int          rmode;
        int          exp_beats;
        logic [63:0] exp_b0;
        logic [63:0] exp_b8;
        logic [15:0] exp_nz;
        logic [15:0] exp_sum;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             fe_snap1, fe_snap0;
    logic [N*8-1:0]   ctr [4];
    logic             busy1, drop1, busy0, drop0;

    int               checks = 0;
    int               failures = 0;
    beat_t            q [2][$];
    logic [63:0]      beats1 [$];
    logic [63:0]      last_trl;
    int               hs_cnt [2];
    int               last_cnt [2];
    int               user_cnt [2];
    int               drops [2];
    bit               stall [2];
    beat_t            prev [2];

    cr_prefix_fe_pack_if pk1 ();
    cr_prefix_fe_pack_if pk0 ();
    assign pk1.pk_tready = rdy;
    assign pk0.pk_tready = rdy;

    cr_prefix_fe_pack #(.N_CTR(N), .TRAILER_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .fe_ctr_1(ctr[0]), .fe_ctr_2(ctr[1]), .fe_ctr_3(ctr[2]), .fe_ctr_4(ctr[3]),
        .fe_snap(fe_snap1), .pk(pk1), .pk_busy(busy1), .pk_snap_drop(drop1)
    );

    cr_prefix_fe_pack #(.N_CTR(N), .TRAILER_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .fe_ctr_1(ctr[0]), .fe_ctr_2(ctr[1]), .fe_ctr_3(ctr[2]), .fe_ctr_4(ctr[3]),
        .fe_snap(fe_snap0), .pk(pk0), .pk_busy(busy0), .pk_snap_drop(drop0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: feature f lives in block f/N, counter f%N; beat w holds features w*8..w*8+7.
    task automatic push_stream(input int d);
        logic [15:0] sum, nz;
        beat_t       e;
        logic [7:0]  b;
        int          f;
        sum = '0;
        nz  = '0;
        for (int w = 0; w < 4 * N / 8; w++) begin
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                f = w * 8 + k;
                b = ctr[f / N][(f % N) * 8 +: 8];
                e.data[k*8 +: 8] = b;
                sum = sum + 16'(b);
                if (b != 8'h00) nz = nz + 16'd1;
            end
            e.last = (d == 0) && (w == 4 * N / 8 - 1);
            e.user = 1'b0;
            q[d].push_back(e);
        end
        if (d == 1) begin
            e.data = {32'h0, nz, sum};
            e.last = 1'b1;
            e.user = 1'b1;
            q[d].push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [63:0] td, input logic tl,
                       input logic tu, input logic bo, input logic dr, input logic sn);
        bit    busy_m, fin_m;
        beat_t e;
        busy_m = (q[d].size() != 0);
        fin_m  = busy_m && rdy && (q[d].size() == 1);
        chk($sformatf("tvalid%0d", d), 64'(v), 64'(busy_m));
        chk($sformatf("busy%0d", d), 64'(bo), 64'(busy_m));
        chk($sformatf("drop%0d", d), 64'(dr), 64'(sn && busy_m && !fin_m));
        if (dr) drops[d]++;
        if (stall[d]) begin
            chk($sformatf("stall_data%0d", d), td, prev[d].data);
            chk($sformatf("stall_meta%0d", d), {62'h0, tl, tu}, {62'h0, prev[d].last, prev[d].user});
        end
        if (v && rdy) begin
            if (q[d].size() == 0) begin
                chk($sformatf("extra_beat%0d", d), 64'd1, 64'd0);
            end else begin
                e = q[d].pop_front();
                chk($sformatf("tdata%0d", d), td, e.data);
                chk($sformatf("tlast_tuser%0d", d), {62'h0, tl, tu}, {62'h0, e.last, e.user});
            end
            hs_cnt[d]++;
            if (tl) last_cnt[d]++;
            if (tu) user_cnt[d]++;
            if (d == 1) begin
                beats1.push_back(td);
                if (tu) last_trl = td;
            end
        end
        stall[d]     = v && !rdy;
        prev[d].data = td;
        prev[d].last = tl;
        prev[d].user = tu;
        if (sn && (!busy_m || fin_m)) push_stream(d);
    endtask

    task automatic tick();
        @(negedge clk);
        mon(1, pk1.pk_tvalid, pk1.pk_tdata, pk1.pk_tlast, pk1.pk_tuser, busy1, drop1, fe_snap1);
        mon(0, pk0.pk_tvalid, pk0.pk_tdata, pk0.pk_tlast, pk0.pk_tuser, busy0, drop0, fe_snap0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int kind);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++)
                case (kind)
                    0: ctr[b][i*8 +: 8] = 8'(i);
                    1: ctr[b][i*8 +: 8] = 8'hFF;
                    2: ctr[b][i*8 +: 8] = 8'h00;
                    3: ctr[b][i*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                    default: ctr[b][i*8 +: 8] = 8'(i) + 8'h40;
                endcase
    endtask

    task automatic run_empty(input int rmode, input int budget);
        for (int n = 0; (q[0].size() != 0) || (q[1].size() != 0); n++) begin
            if (n >= budget) begin
                chk("stream_timeout", 64'd1, 64'd0);
                q[0].delete();
                q[1].delete();
                break;
            end
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = (n % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tick();
        end
    endtask

    task automatic snap1_pulse();
        fe_snap1 = 1'b1;
        tick();
        fe_snap1 = 1'b0;
    endtask

    task automatic clear_stats();
        beats1.delete();
        for (int d = 0; d < 2; d++) begin
            hs_cnt[d] = 0; last_cnt[d] = 0; user_cnt[d] = 0; drops[d] = 0;
        end
        last_trl = '0;
    endtask

    task automatic wait_hs1(input int target, input int budget);
        for (int n = 0; hs_cnt[1] < target; n++) begin
            if (n >= budget) begin
                chk("hs_timeout", 64'd1, 64'd0);
                break;
            end
            rdy = 1'b1;
            tick();
        end
    endtask

    vec_t tbl [3];

    initial begin
        tbl[0] = '{0, 0, 33, 64'h0706050403020100, 64'h0706050403020100, 16'd252, 16'h1F80};
        tbl[1] = '{1, 1, 33, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 16'd256, 16'hFF00};
        tbl[2] = '{2, 2, 33, 64'h0, 64'h0, 16'd0, 16'h0};

        rst = 1'b1; rdy = 1'b0; fe_snap1 = 1'b0; fe_snap0 = 1'b0;
        for (int d = 0; d < 2; d++) begin stall[d] = 1'b0; prev[d] = '{'0, 1'b0, 1'b0}; end
        clear_stats();
        fill(2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(pk1.pk_tvalid), 64'd0);
        chk("rst_tdata", pk1.pk_tdata, 64'd0);
        chk("rst_flags", {60'h0, pk1.pk_tlast, pk1.pk_tuser, busy1, drop1}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 3; t++) begin
            clear_stats();
            fill(tbl[t].fill);
            snap1_pulse();
            run_empty(tbl[t].rmode, 400);
            chk($sformatf("v%0d_beats", t), 64'(hs_cnt[1]), 64'(tbl[t].exp_beats));
            chk($sformatf("v%0d_beat0", t), (beats1.size() > 0) ? beats1[0] : 64'hX, tbl[t].exp_b0);
            chk($sformatf("v%0d_beat8", t), (beats1.size() > 8) ? beats1[8] : 64'hX, tbl[t].exp_b8);
            chk($sformatf("v%0d_nz", t), 64'(last_trl[31:16]), 64'(tbl[t].exp_nz));
            chk($sformatf("v%0d_sum", t), 64'(last_trl[15:0]), 64'(tbl[t].exp_sum));
            chk($sformatf("v%0d_tlast", t), 64'(last_cnt[1]), 64'd1);
        end

        // fe_snap at beat 5 is dropped; the original snapshot is streamed.
        clear_stats();
        fill(0);
        snap1_pulse();
        wait_hs1(5, 50);
        fill(4);
        snap1_pulse();
        run_empty(0, 200);
        chk("drop_once", 64'(drops[1]), 64'd1);
        chk("drop_orig_sum", 64'(last_trl[15:0]), 64'h1F80);

        // fe_snap coincident with the trailer handshake starts the next snapshot directly.
        clear_stats();
        fill(0);
        snap1_pulse();
        for (int n = 0; q[1].size() > 1; n++) begin
            if (n >= 100) begin chk("coinc_timeout", 64'd1, 64'd0); break; end
            rdy = 1'b1;
            tick();
        end
        fill(1);
        fe_snap1 = 1'b1;
        tick();
        fe_snap1 = 1'b0;
        chk("coinc_no_drop", 64'(drops[1]), 64'd0);
        beats1.delete();
        tick();
        chk("coinc_first_beat", (beats1.size() == 1) ? beats1[0] : 64'hX, 64'hFFFFFFFFFFFFFFFF);
        run_empty(0, 200);

        // No-trailer variant: 32 zero beats, tlast only on the last, tuser never.
        clear_stats();
        fill(2);
        fe_snap0 = 1'b1;
        tick();
        fe_snap0 = 1'b0;
        run_empty(0, 200);
        chk("ntr_beats", 64'(hs_cnt[0]), 64'd32);
        chk("ntr_tlast", 64'(last_cnt[0]), 64'd1);
        chk("ntr_tuser", 64'(user_cnt[0]), 64'd0);

        // Asynchronous reset mid-stream, then a clean restart.
        clear_stats();
        fill(3);
        snap1_pulse();
        wait_hs1(10, 50);
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(pk1.pk_tvalid), 64'd0);
        chk("arst_tdata", pk1.pk_tdata, 64'd0);
        chk("arst_flags", {61'h0, pk1.pk_tlast, pk1.pk_tuser, busy1}, 64'd0);
        q[0].delete();
        q[1].delete();
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_stats();
        fill(0);
        snap1_pulse();
        run_empty(0, 200);
        chk("arst_restart_beat0", (beats1.size() > 0) ? beats1[0] : 64'hX, 64'h0706050403020100);
        chk("arst_restart_sums", last_trl, {32'h0, 16'd252, 16'h1F80});

        // Randomized traffic: random counters, ready and stray snapshots.
        for (int it = 0; it < 6; it++) begin
            fill(3);
            snap1_pulse();
            for (int n = 0; q[1].size() != 0; n++) begin
                if (n >= 2000) begin chk("rand_timeout", 64'd1, 64'd0); q[1].delete(); break; end
                rdy      = 1'($urandom_range(0, 1));
                fe_snap1 = (n < 300) && ($urandom_range(0, 15) == 0);
                if (fe_snap1) fill(3);
                tick();
            end
            fe_snap1 = 1'b0;
        end
        rdy = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
